// File: rtl/clk_div_ratio_ctrl_if.sv
// rtl/clk_div_ratio_ctrl_if.sv - ratio request handshake between register file and sequencer
interface clk_div_ratio_ctrl_if #(
   parameter int DIV_WIDTH = 8
);
   logic                 i_cfg_valid;
   logic [DIV_WIDTH-1:0] i_cfg_ratio;
   logic                 o_cfg_ready;

   modport master (
      output i_cfg_valid,
      output i_cfg_ratio,
      input  o_cfg_ready
   );

   modport slave (
      input  i_cfg_valid,
      input  i_cfg_ratio,
      output o_cfg_ready
   );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - sequences new division ratios into the clock divider
// Gates the divider off, drains, loads the ratio, settles, then re-enables.
module clk_div_ratio_ctrl #(
   parameter int DIV_WIDTH   = 8,
   parameter int SETTLE_CYC  = 4,
   parameter int RESET_RATIO = 1
) (
   input  logic                 i_ref_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   clk_div_ratio_ctrl_if.slave  cfg,
   input  logic                 i_err_clr,
   output logic                 o_clk_en,
   output logic [DIV_WIDTH-1:0] o_div_ratio,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);
   localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      LOAD,
      SETTLE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] pend_q, pend_d;
   logic [DIV_WIDTH-1:0] ratio_d;
   logic                 clk_en_d, done_d, err_d, ready_q, ready_d, busy_d;

   assign cfg.o_cfg_ready = ready_q;

   always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_q      <= '0;
         o_clk_en    <= 1'b0;
         o_div_ratio <= DIV_WIDTH'(RESET_RATIO);
         ready_q     <= 1'b1;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         o_clk_en    <= clk_en_d;
         o_div_ratio <= ratio_d;
         ready_q     <= ready_d;
         o_busy      <= busy_d;
         o_done      <= done_d;
         o_err       <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      clk_en_d = o_clk_en;
      ratio_d  = o_div_ratio;
      done_d   = 1'b0;
      // a clear is overridden below by a same-edge reject
      err_d    = i_err_clr ? 1'b0 : o_err;

      case (state_q)
         IDLE: begin
            clk_en_d = i_enable;
            if (cfg.i_cfg_valid) begin
               pend_d = cfg.i_cfg_ratio;
               if (cfg.i_cfg_ratio == '0) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else if (cfg.i_cfg_ratio == o_div_ratio) begin
                  done_d = 1'b1;
               end else begin
                  clk_en_d = 1'b0;
                  state_d  = DRAIN;
                  cnt_d    = '0;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOAD: begin
            ratio_d = pend_q;
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d  = IDLE;
               cnt_d    = '0;
               clk_en_d = i_enable;
               done_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end
endmodule
